// File: rtl/shift_operand_ctrl_pkg.sv
// Shared definitions for the operand-2 decode stage in front of the 32-bit
// barrel shifter: shift-type codes, FSM state encoding, instruction field
// positions and the packed bundle of barrel/override fields.
// No ports (package).
package shift_operand_ctrl_pkg;

    localparam int OP_W = 32;

    // Barrel shifter shift-type codes
    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RS_WAIT = 2'b01,
        ST_OUT     = 2'b10
    } state_t;

    // Data-processing instruction field positions
    localparam int FLD_I         = 25;
    localparam int FLD_REGSHIFT  = 4;
    localparam int FLD_TYPE_HI   = 6;
    localparam int FLD_TYPE_LO   = 5;
    localparam int FLD_IMMAMT_HI = 11;
    localparam int FLD_IMMAMT_LO = 7;
    localparam int FLD_RS_HI     = 11;
    localparam int FLD_RS_LO     = 8;
    localparam int FLD_ROT_HI    = 11;
    localparam int FLD_ROT_LO    = 8;
    localparam int FLD_IMM8_HI   = 7;

    // Everything the stage presents downstream, besides Out_Valid
    typedef struct packed {
        logic            enable;
        logic [OP_W-1:0] input_bus;
        logic [1:0]      shift_type;
        logic [4:0]      shift_amt;
        logic            cin;
        logic            ovr_valid;
        logic [OP_W-1:0] ovr_result;
        logic            ovr_cout;
    } operand_t;

endpackage

// File: rtl/shift_amt_map.sv
// Combinational mapping of a register-specified shift onto the 5-bit barrel
// shifter encoding, or onto an override result when the encoding cannot
// express the amount.
// Ports:
//   shift_type  in   shift type from Instr[6:5]
//   amount      in   Rs[7:0]; upper Rs bits are irrelevant to the shift
//   rm          in   Rm operand
//   cin         in   CPSR C
//   fields      out  barrel and override fields
module shift_amt_map
    import shift_operand_ctrl_pkg::*;
(
    input  logic [1:0]      shift_type,
    input  logic [7:0]      amount,
    input  logic [OP_W-1:0] rm,
    input  logic            cin,
    output operand_t        fields
);

    always_comb begin
        fields            = '0;
        fields.input_bus  = rm;
        fields.shift_type = shift_type;
        fields.cin        = cin;
        // Amount 0 leaves the barrel disabled: operand Rm, carry C.
        if (amount != 8'd0) begin
            if (amount < 8'd32) begin
                fields.enable    = 1'b1;
                fields.shift_amt = amount[4:0];
            end else begin
                case (shift_type)
                    SHIFT_LSL: begin
                        // Only a shift of exactly 32 moves Rm[0] into carry.
                        fields.ovr_valid = 1'b1;
                        fields.ovr_cout  = (amount == 8'd32) ? rm[0] : 1'b0;
                    end
                    SHIFT_LSR: begin
                        if (amount == 8'd32) begin
                            // Barrel LSR#0 already means LSR by 32.
                            fields.enable = 1'b1;
                        end else begin
                            fields.ovr_valid = 1'b1;
                        end
                    end
                    SHIFT_ASR: begin
                        // ASR by 32 or more equals ASR#32 (sign fill).
                        fields.enable = 1'b1;
                    end
                    default: begin
                        if (amount[4:0] == 5'd0) begin
                            // Full rotations: value unchanged, carry = bit 31.
                            fields.ovr_valid  = 1'b1;
                            fields.ovr_result = rm;
                            fields.ovr_cout   = rm[OP_W-1];
                        end else begin
                            fields.enable    = 1'b1;
                            fields.shift_amt = amount[4:0];
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_operand_ctrl.sv
// Operand-2 decode stage feeding the 32-bit barrel shifter. Accepts a
// data-processing instruction with Rm and C, fetches Rs for register-specified
// shifts, and presents registered barrel fields (or an override result).
// Optional build macro SHIFT_OPERAND_CTRL_RS_SINGLE_CYCLE_EN: Rs_Data is valid
// in the accept cycle, RS_WAIT is skipped and every form has 1-cycle latency.
// Ports:
//   SOC_Clk, SOC_Reset (sync, active high), SOC_Flush
//   SOC_Instr_Valid/SOC_Instr_Ready, SOC_Instr, SOC_Rm_Data, SOC_C_Flag
//   SOC_Rs_Req, SOC_Rs_Addr, SOC_Rs_Data   register-file Rs read
//   SOC_Out_Valid/SOC_Out_Ready, SOC_BS_*  barrel shifter fields
//   SOC_Ovr_Valid, SOC_Ovr_Result, SOC_Ovr_Cout  override operand
//   dbg_state                              current FSM state
// Handshake: a transfer happens on a rising edge where Valid and Ready are
// both 1. Out fields stay stable while Out_Valid=1 and Out_Ready=0; Instr_Ready
// depends combinationally on Out_Ready so accepts can run back to back.
module shift_operand_ctrl
    import shift_operand_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4
) (
    input  logic               SOC_Clk,
    input  logic               SOC_Reset,
    input  logic               SOC_Flush,
    input  logic               SOC_Instr_Valid,
    output logic               SOC_Instr_Ready,
    input  logic [31:0]        SOC_Instr,
    input  logic [DATA_W-1:0]  SOC_Rm_Data,
    input  logic               SOC_C_Flag,
    output logic               SOC_Rs_Req,
    output logic [RADDR_W-1:0] SOC_Rs_Addr,
    input  logic [DATA_W-1:0]  SOC_Rs_Data,
    output logic               SOC_Out_Valid,
    input  logic               SOC_Out_Ready,
    output logic               SOC_BS_Enable,
    output logic [DATA_W-1:0]  SOC_BS_Input_Bus,
    output logic [1:0]         SOC_BS_Shift_Type,
    output logic [4:0]         SOC_BS_Shift_Amt,
    output logic               SOC_BS_Cin,
    output logic               SOC_Ovr_Valid,
    output logic [DATA_W-1:0]  SOC_Ovr_Result,
    output logic               SOC_Ovr_Cout,
    output state_t             dbg_state
);

    state_t   state;
    operand_t fields_q;
    operand_t imm_fields;
    operand_t map_fields;
    logic     out_valid;
    logic     is_reg_shift;
    logic     accept;

    logic [1:0]      map_type;
    logic [7:0]      map_amount;
    logic [OP_W-1:0] map_rm;
    logic            map_cin;

    // Instruction bits that carry no operand-2 information
    logic unused_bits;
    assign unused_bits = ^{SOC_Instr[31:26], SOC_Instr[24:12], SOC_Rs_Data[DATA_W-1:8]};

    assign is_reg_shift = !SOC_Instr[FLD_I] && SOC_Instr[FLD_REGSHIFT];

    // Flush and reset both block a new offer in the same cycle.
    assign SOC_Instr_Ready = !SOC_Reset && !SOC_Flush &&
                             ((state == ST_IDLE) || ((state == ST_OUT) && SOC_Out_Ready));
    assign accept      = SOC_Instr_Valid && SOC_Instr_Ready;
    assign SOC_Rs_Req  = accept && is_reg_shift;
    assign SOC_Rs_Addr = SOC_Rs_Req ? RADDR_W'(SOC_Instr[FLD_RS_HI:FLD_RS_LO]) : '0;

    // Immediate operand and immediate-shift forms
    always_comb begin
        imm_fields     = '0;
        imm_fields.cin = SOC_C_Flag;
        if (SOC_Instr[FLD_I]) begin
            imm_fields.input_bus = OP_W'(SOC_Instr[FLD_IMM8_HI:0]);
            if (SOC_Instr[FLD_ROT_HI:FLD_ROT_LO] != 4'd0) begin
                imm_fields.enable     = 1'b1;
                imm_fields.shift_type = SHIFT_ROR;
                imm_fields.shift_amt  = {SOC_Instr[FLD_ROT_HI:FLD_ROT_LO], 1'b0};
            end
        end else begin
            // #0 encodings (LSR/ASR #32, RRX) are the barrel's own meaning.
            imm_fields.enable     = 1'b1;
            imm_fields.shift_type = SOC_Instr[FLD_TYPE_HI:FLD_TYPE_LO];
            imm_fields.shift_amt  = SOC_Instr[FLD_IMMAMT_HI:FLD_IMMAMT_LO];
            imm_fields.input_bus  = SOC_Rm_Data;
        end
    end

`ifdef SHIFT_OPERAND_CTRL_RS_SINGLE_CYCLE_EN
    // Rs arrives with the instruction, so map straight from the live inputs.
    assign map_type   = SOC_Instr[FLD_TYPE_HI:FLD_TYPE_LO];
    assign map_amount = SOC_Rs_Data[7:0];
    assign map_rm     = SOC_Rm_Data;
    assign map_cin    = SOC_C_Flag;
`else
    logic [1:0]      lat_type;
    logic [OP_W-1:0] lat_rm;
    logic            lat_cin;

    // Rs returns one cycle after the request; the rest was latched at accept.
    assign map_type   = lat_type;
    assign map_amount = SOC_Rs_Data[7:0];
    assign map_rm     = lat_rm;
    assign map_cin    = lat_cin;
`endif

    shift_amt_map u_map (
        .shift_type (map_type),
        .amount     (map_amount),
        .rm         (map_rm),
        .cin        (map_cin),
        .fields     (map_fields)
    );

    always_ff @(posedge SOC_Clk) begin
        if (SOC_Reset) begin
            state     <= ST_IDLE;
            fields_q  <= '0;
            out_valid <= 1'b0;
`ifndef SHIFT_OPERAND_CTRL_RS_SINGLE_CYCLE_EN
            lat_type  <= 2'b00;
            lat_rm    <= '0;
            lat_cin   <= 1'b0;
`endif
        end else if (SOC_Flush) begin
            state              <= ST_IDLE;
            out_valid          <= 1'b0;
            fields_q.ovr_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_OUT: begin
                    if (accept) begin
                        if (is_reg_shift) begin
`ifdef SHIFT_OPERAND_CTRL_RS_SINGLE_CYCLE_EN
                            fields_q  <= map_fields;
                            out_valid <= 1'b1;
                            state     <= ST_OUT;
`else
                            lat_type           <= SOC_Instr[FLD_TYPE_HI:FLD_TYPE_LO];
                            lat_rm             <= SOC_Rm_Data;
                            lat_cin            <= SOC_C_Flag;
                            out_valid          <= 1'b0;
                            fields_q.ovr_valid <= 1'b0;
                            state              <= ST_RS_WAIT;
`endif
                        end else begin
                            fields_q  <= imm_fields;
                            out_valid <= 1'b1;
                            state     <= ST_OUT;
                        end
                    end else if ((state == ST_OUT) && SOC_Out_Ready) begin
                        out_valid          <= 1'b0;
                        fields_q.ovr_valid <= 1'b0;
                        state              <= ST_IDLE;
                    end
                end
                ST_RS_WAIT: begin
                    fields_q  <= map_fields;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign SOC_Out_Valid     = out_valid;
    assign SOC_BS_Enable     = fields_q.enable;
    assign SOC_BS_Input_Bus  = fields_q.input_bus;
    assign SOC_BS_Shift_Type = fields_q.shift_type;
    assign SOC_BS_Shift_Amt  = fields_q.shift_amt;
    assign SOC_BS_Cin        = fields_q.cin;
    assign SOC_Ovr_Valid     = fields_q.ovr_valid;
    assign SOC_Ovr_Result    = fields_q.ovr_result;
    assign SOC_Ovr_Cout      = fields_q.ovr_cout;
    assign dbg_state         = state;

endmodule

// File: tb/tb_shift_operand_ctrl.sv
// Self-checking bench for shift_operand_ctrl. The reference model computes
// the ARM operand-2 value and shifter carry directly from the instruction,
// Rm, Rs and C; the DUT result is reconstructed through a model of the
// 5-bit-encoded barrel shifter (or taken from the override fields).
module tb_shift_operand_ctrl;
    import shift_operand_ctrl_pkg::*;

`ifdef SHIFT_OPERAND_CTRL_RS_SINGLE_CYCLE_EN
    localparam int REG_LAT = 1;
`else
    localparam int REG_LAT = 2;
`endif

    logic        clk;
    logic        reset;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] rm_data;
    logic        c_flag;
    logic        rs_req;
    logic [3:0]  rs_addr;
    logic [31:0] rs_data;
    logic        out_valid;
    logic        out_ready;
    logic        bs_enable;
    logic [31:0] bs_bus;
    logic [1:0]  bs_type;
    logic [4:0]  bs_amt;
    logic        bs_cin;
    logic        ovr_valid;
    logic [31:0] ovr_result;
    logic        ovr_cout;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    shift_operand_ctrl dut (
        .SOC_Clk           (clk),
        .SOC_Reset         (reset),
        .SOC_Flush         (flush),
        .SOC_Instr_Valid   (instr_valid),
        .SOC_Instr_Ready   (instr_ready),
        .SOC_Instr         (instr),
        .SOC_Rm_Data       (rm_data),
        .SOC_C_Flag        (c_flag),
        .SOC_Rs_Req        (rs_req),
        .SOC_Rs_Addr       (rs_addr),
        .SOC_Rs_Data       (rs_data),
        .SOC_Out_Valid     (out_valid),
        .SOC_Out_Ready     (out_ready),
        .SOC_BS_Enable     (bs_enable),
        .SOC_BS_Input_Bus  (bs_bus),
        .SOC_BS_Shift_Type (bs_type),
        .SOC_BS_Shift_Amt  (bs_amt),
        .SOC_BS_Cin        (bs_cin),
        .SOC_Ovr_Valid     (ovr_valid),
        .SOC_Ovr_Result    (ovr_result),
        .SOC_Ovr_Cout      (ovr_cout),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference models ----------------
    // ARM register-amount shift: {carry, value}
    function automatic logic [32:0] arm_shift(input logic [1:0] t, input logic [7:0] n,
                                              input logic [31:0] rm, input logic c);
        logic [63:0] w;
        logic [32:0] r;
        int rot;
        r = {c, rm};
        if (n != 8'd0) begin
            case (t)
                2'b00: begin w = {32'b0, rm} << n; r = {w[32], w[31:0]}; end
                2'b01: begin w = {rm, 32'b0} >> n; r = {w[31], w[63:32]}; end
                2'b10: begin w = $signed({rm, 32'b0}) >>> n; r = {w[31], w[63:32]}; end
                default: begin
                    rot = int'(n) % 32;
                    if (rot == 0) r = {rm[31], rm};
                    else begin w = {rm, rm} >> rot; r = {w[31], w[31:0]}; end
                end
            endcase
        end
        return r;
    endfunction

    function automatic logic [32:0] arm_operand(input logic [31:0] ins, input logic [31:0] rm,
                                                input logic [31:0] rs, input logic c);
        logic [63:0] w;
        logic [32:0] r;
        logic [4:0]  a;
        logic [7:0]  imm;
        int rot2;
        if (ins[25]) begin
            imm  = ins[7:0];
            rot2 = 2 * int'(ins[11:8]);
            w = {24'b0, imm, 24'b0, imm} >> rot2;
            r = (rot2 == 0) ? {c, w[31:0]} : {w[31], w[31:0]};
        end else if (!ins[4]) begin
            a = ins[11:7];
            if (a != 5'd0) r = arm_shift(ins[6:5], {3'b0, a}, rm, c);
            else if (ins[6:5] == 2'b00) r = {c, rm};
            else if (ins[6:5] == 2'b11) r = {rm[0], c, rm[31:1]};
            else r = arm_shift(ins[6:5], 8'd32, rm, c);
        end else begin
            r = arm_shift(ins[6:5], rs[7:0], rm, c);
        end
        return r;
    endfunction

    function automatic logic exp_override(input logic [31:0] ins, input logic [31:0] rs);
        logic [7:0] n;
        logic o;
        n = rs[7:0];
        o = 1'b0;
        if (!ins[25] && ins[4]) begin
            case (ins[6:5])
                2'b00: o = (n >= 8'd32);
                2'b01: o = (n > 8'd32);
                2'b10: o = 1'b0;
                default: o = (n != 8'd0) && ((int'(n) % 32) == 0);
            endcase
        end
        return o;
    endfunction

    // Barrel shifter with the 5-bit encoding: {cout, result}
    function automatic logic [32:0] barrel(input logic en, input logic [1:0] t, input logic [4:0] amt,
                                           input logic [31:0] d, input logic ci);
        logic [63:0] w;
        logic [32:0] r;
        r = {ci, d};
        if (en) begin
            case (t)
                2'b00: if (amt != 5'd0) begin w = {32'b0, d} << amt; r = {w[32], w[31:0]}; end
                2'b01: if (amt == 5'd0) r = {d[31], 32'b0};
                       else begin w = {d, 32'b0} >> amt; r = {w[31], w[63:32]}; end
                2'b10: if (amt == 5'd0) r = {d[31], {32{d[31]}}};
                       else begin w = $signed({d, 32'b0}) >>> amt; r = {w[31], w[63:32]}; end
                default: if (amt == 5'd0) r = {d[0], ci, d[31:1]};
                         else begin w = {d, d} >> amt; r = {w[31], w[31:0]}; end
            endcase
        end
        return r;
    endfunction

    function automatic logic [32:0] observed();
        return ovr_valid ? {ovr_cout, ovr_result} : barrel(bs_enable, bs_type, bs_amt, bs_bus, bs_cin);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One transaction with Out_Ready=1; returns at the negedge where Out_Valid=1.
    task automatic run_txn(input string tag, input logic [31:0] ins, input logic [31:0] rm,
                           input logic [31:0] rs, input logic c);
        logic reg_shift;
        int lat;
        reg_shift = !ins[25] && ins[4];
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = ins;
        rm_data     = rm;
        rs_data     = rs;
        c_flag      = c;
        out_ready   = 1'b1;
        #1;
        check({tag, "_ready"}, 64'(instr_ready), 64'd1);
        check({tag, "_rs_req"}, 64'(rs_req), 64'(reg_shift));
        if (reg_shift) check({tag, "_rs_addr"}, 64'(rs_addr), 64'(ins[11:8]));
        @(negedge clk);
        // Scramble everything but Rs so only latched values can be used.
        instr_valid = 1'b0;
        instr       = $urandom;
        rm_data     = $urandom;
        c_flag      = 1'($urandom_range(0, 1));
        lat = 1;
        while (!out_valid && lat < 5) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), reg_shift ? 64'(REG_LAT) : 64'd1);
        check({tag, "_operand"}, 64'(observed()), 64'(arm_operand(ins, rm, rs, c)));
        check({tag, "_ovr_valid"}, 64'(ovr_valid), 64'(exp_override(ins, rs)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_ovr_valid"}, 64'(ovr_valid), 64'd0);
        check({tag, "_bs_enable"}, 64'(bs_enable), 64'd0);
        check({tag, "_bs_bus"}, 64'(bs_bus), 64'd0);
        check({tag, "_bs_type"}, 64'(bs_type), 64'd0);
        check({tag, "_bs_amt"}, 64'(bs_amt), 64'd0);
        check({tag, "_bs_cin"}, 64'(bs_cin), 64'd0);
        check({tag, "_ovr_result"}, 64'(ovr_result), 64'd0);
        check({tag, "_ovr_cout"}, 64'(ovr_cout), 64'd0);
        check({tag, "_instr_ready"}, 64'(instr_ready), 64'd0);
        check({tag, "_rs_req"}, 64'(rs_req), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] itm_instr[3];
    logic [31:0] itm_rm[3];
    logic        itm_c[3];

    initial begin
        int nxt;
        int seen;
        logic [31:0] ins;
        logic [31:0] rs;
        logic [7:0]  n;

        reset = 1'b1; flush = 1'b0; instr_valid = 1'b0; instr = '0;
        rm_data = '0; c_flag = 1'b0; rs_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        out_ready = 1'b1;

        // Immediate, rot=0
        run_txn("imm_rot0", 32'hE3A000FF, 32'h12345678, 32'h0, 1'b1);
        check("imm_rot0_enable", 64'(bs_enable), 64'd0);
        check("imm_rot0_bus", 64'(bs_bus), 64'h000000FF);
        check("imm_rot0_cin", 64'(bs_cin), 64'd1);

        // Immediate, rot=4, imm8=0x3F
        run_txn("imm_rot4", 32'hE3A0043F, 32'h0, 32'h0, 1'b0);
        check("imm_rot4_enable", 64'(bs_enable), 64'd1);
        check("imm_rot4_type", 64'(bs_type), 64'd3);
        check("imm_rot4_amt", 64'(bs_amt), 64'd8);
        check("imm_rot4_bus", 64'(bs_bus), 64'h3F);
        check("imm_rot4_value", 64'(observed()), 64'h0_3F000000);

        // Register LSL by 32 and 33
        run_txn("lsl32", 32'hE1A00211, 32'h00000001, 32'd32, 1'b0);
        check("lsl32_ovr", 64'({ovr_valid, ovr_cout, ovr_result}), {31'b0, 1'b1, 1'b1, 32'h0});
        run_txn("lsl33", 32'hE1A00211, 32'h00000001, 32'd33, 1'b1);
        check("lsl33_ovr", 64'({ovr_valid, ovr_cout, ovr_result}), {31'b0, 1'b1, 1'b0, 32'h0});

        // Register ROR by 64, LSR by 32
        run_txn("ror64", 32'hE1A00271, 32'h80000000, 32'd64, 1'b0);
        check("ror64_ovr", 64'({ovr_valid, ovr_cout, ovr_result}), {31'b0, 1'b1, 1'b1, 32'h80000000});
        run_txn("lsr32", 32'hE1A00231, 32'hF0000001, 32'd32, 1'b0);
        check("lsr32_fields", 64'({ovr_valid, bs_enable, bs_type, bs_amt}), {55'b0, 1'b0, 1'b1, 2'b01, 5'd0});

        // Back-to-back immediate shifts with a stalled consumer
        for (int i = 0; i < 3; i++) begin
            itm_instr[i] = 32'hE1A00000 | ($urandom & 32'h00000FEF);
            itm_rm[i]    = $urandom;
            itm_c[i]     = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        out_ready = 1'b0;
        instr_valid = 1'b1; instr = itm_instr[0]; rm_data = itm_rm[0]; c_flag = itm_c[0];
        #1;
        check("b2b_first_ready", 64'(instr_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back(arm_operand(itm_instr[0], itm_rm[0], 32'h0, itm_c[0]));
        @(negedge clk);
        instr = itm_instr[1]; rm_data = itm_rm[1]; c_flag = itm_c[1];
        for (int k = 0; k < 3; k++) begin
            #1;
            check("b2b_hold_valid", 64'(out_valid), 64'd1);
            check("b2b_hold_ready", 64'(instr_ready), 64'd0);
            check("b2b_hold_value", 64'(observed()), 64'(exp_q[0]));
            @(negedge clk);
        end
        out_ready = 1'b1;
        nxt = 1;
        seen = 0;
        for (int cyc = 0; cyc < 12 && seen < 3; cyc++) begin
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) check("b2b_extra_output", 64'd1, 64'd0);
                else check("b2b_stream_value", 64'(observed()), 64'(exp_q.pop_front()));
                seen++;
            end
            if (instr_valid && instr_ready) begin
                exp_q.push_back(arm_operand(itm_instr[nxt], itm_rm[nxt], 32'h0, itm_c[nxt]));
                nxt++;
            end
            @(negedge clk);
            if (nxt < 3) begin
                instr = itm_instr[nxt]; rm_data = itm_rm[nxt]; c_flag = itm_c[nxt];
            end else begin
                instr_valid = 1'b0;
            end
        end
        #1;
        check("b2b_outputs_seen", 64'(seen), 64'd3);
        check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
        check("b2b_no_duplicate", 64'(out_valid), 64'd0);

        // Flush while waiting for Rs, with a competing offer
        @(negedge clk);
        instr_valid = 1'b1; instr = 32'hE1A00211; rm_data = 32'h1; rs_data = 32'd32; c_flag = 1'b0;
        #1;
        check("flush_accept_ready", 64'(instr_ready), 64'd1);
        @(negedge clk);
        flush = 1'b1; instr_valid = 1'b1; instr = 32'hE3A000FF;
        #1;
        check("flush_blocks_ready", 64'(instr_ready), 64'd0);
        check("flush_blocks_rs_req", 64'(rs_req), 64'd0);
        @(negedge clk);
        flush = 1'b0; instr_valid = 1'b0;
        #1;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        #1;
        check("flush_out_valid_later", 64'(out_valid), 64'd0);

        // Reset while presenting an output
        @(negedge clk);
        out_ready = 1'b0;
        instr_valid = 1'b1; instr = 32'hE3A0043F; c_flag = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("rst_mid_out_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("rst_mid_out");
        reset = 1'b0;
        out_ready = 1'b1;

        // Randomized mix of all three forms
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0: ins = 32'hE3A00000 | ($urandom & 32'h00000FFF);
                1: ins = 32'hE1A00000 | ($urandom & 32'h00000FEF);
                default: ins = 32'hE1A00010 | ($urandom & 32'h00000F6F);
            endcase
            case ($urandom_range(0, 4))
                0: n = 8'd0;
                1: n = 8'($urandom_range(1, 31));
                2: n = 8'd32;
                3: n = 8'($urandom_range(33, 255));
                default: n = 8'(32 * $urandom_range(1, 7));
            endcase
            rs = ($urandom & 32'hFFFFFF00) | {24'b0, n};
            run_txn("random", ins, $urandom, rs, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
